// File: rtl/mem_port_ctrl_pkg.sv
// Shared definitions for the unified-memory port controller: access size
// encodings, the controller state encoding and a canonical no-op word.
package mem_port_ctrl_pkg;

  // Access size encodings carried on ls_size (2'b11 behaves as a word)
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Controller states: fetch owns the memory by default, LS_RESP is the
  // single response cycle following a stolen load/store cycle
  typedef enum logic {
    ST_FETCH   = 1'b0,
    ST_LS_RESP = 1'b1
  } state_e;

  // Canonical no-op instruction word (addi x0, x0, 0)
  localparam logic [31:0] NOP = 32'h0000_0013;

  // A halfword must sit on an even address, a word on a multiple of four
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (size == SZ_H) begin
      mis = offset[0];
    end else if (size[1]) begin
      mis = (offset != 2'b00);
    end
    return mis;
  endfunction

endpackage : mem_port_ctrl_pkg

// File: rtl/mem_port_ctrl_ls_lane_align.sv
// Combinational byte-lane logic for the load/store path.
// Memory byte offset k lives in data[31-8k -: 8]; CPU-side values are
// little-endian and LSB-aligned. Store steering works from the live request,
// load extraction works from the fields latched in the request cycle.
module ls_lane_align
  import mem_port_ctrl_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_lanes,
  output logic        st_misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [2:0] st_nbytes;
  logic [7:0] rd_byte [4];
  logic [7:0] b0;
  logic [7:0] b1;

  assign st_misaligned = is_misaligned(st_size, st_off);

  // Number of bytes a store of the given size touches
  always_comb begin
    st_nbytes = 3'd4;
    case (st_size)
      SZ_B:    st_nbytes = 3'd1;
      SZ_H:    st_nbytes = 3'd2;
      default: st_nbytes = 3'd4;
    endcase
  end

  // Per-lane steering: lane k takes CPU byte (k - offset) and is strobed when
  // that byte index falls inside the access
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic [1:0] rel;
    assign rel              = LANE - st_off;
    assign st_lanes[31-8*gi -: 8] = st_wdata[{rel, 3'b000} +: 8];
    assign st_wstrb[gi]     = (LANE >= st_off) && ({1'b0, rel} < st_nbytes);
    assign rd_byte[gi]      = ld_rdata[31-8*gi -: 8];
  end

  assign b0 = rd_byte[ld_off];
  assign b1 = rd_byte[ld_off + 2'd1];

  // Reassemble the addressed bytes little-endian and extend
  always_comb begin
    ld_value = 32'h0;
    case (ld_size)
      SZ_B:    ld_value = {{24{~ld_unsigned & b0[7]}}, b0};
      SZ_H:    ld_value = {{16{~ld_unsigned & b1[7]}}, b1, b0};
      default: ld_value = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
    endcase
  end

endmodule : ls_lane_align

// File: rtl/mem_port_ctrl.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Fetch owns the memory by default; a load/store steals one cycle (fetch is
// stalled for exactly that cycle) and its result is returned the next cycle.
// The instruction word arriving during the stolen cycle is parked in
// inst_hold and replayed to fetch during the response cycle.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int AW    = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_stall,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [1:0]       ls_size,
  input  logic             ls_unsigned,
  input  logic [AW-1:0]    ls_addr,
  input  logic [31:0]      ls_wdata,
  output logic [31:0]      ls_rdata,
  output logic             ls_ready,
  output logic             ls_err,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [AW-1:0]    WORD_MASK = ~AW'(3);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [31:0]      inst_hold_q, inst_hold_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [3:0]  st_wstrb;
  logic [31:0] st_lanes;
  logic        st_misaligned;
  logic [31:0] ld_value;
  logic        grant;

  ls_lane_align u_align (
    .st_size       (ls_size),
    .st_off        (ls_addr[1:0]),
    .st_wdata      (ls_wdata),
    .st_wstrb      (st_wstrb),
    .st_lanes      (st_lanes),
    .st_misaligned (st_misaligned),
    .ld_size       (size_q),
    .ld_off        (off_q),
    .ld_unsigned   (uns_q),
    .ld_rdata      (mem_rdata),
    .ld_value      (ld_value)
  );

  // While reset is held no request is granted, keeping stall/write outputs idle
  assign grant     = ls_req & rst_n;
  assign stall_cnt = stall_cnt_q;

  // State, latched request fields, held instruction and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      inst_hold_q <= 32'h0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      inst_hold_q <= inst_hold_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      we_q        <= we_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic and all memory / fetch / load-store outputs
  always_comb begin
    state_d     = state_q;
    inst_hold_d = inst_hold_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    we_d        = we_q;
    err_d       = err_q;

    mem_addr    = if_addr & WORD_MASK;
    mem_we      = 1'b0;
    mem_wstrb   = 4'b0000;
    mem_wdata   = 32'h0;
    if_stall    = 1'b0;
    if_rdata    = mem_rdata;
    ls_ready    = 1'b0;
    ls_err      = 1'b0;
    ls_rdata    = 32'h0;

    case (state_q)
      ST_FETCH: begin
        if (grant) begin
          if_stall    = 1'b1;
          inst_hold_d = mem_rdata;
          size_d      = ls_size;
          uns_d       = ls_unsigned;
          off_d       = ls_addr[1:0];
          we_d        = ls_we;
          err_d       = st_misaligned;
          state_d     = ST_LS_RESP;
          if (!st_misaligned) begin
            mem_addr = ls_addr & WORD_MASK;
            mem_we   = ls_we;
            if (ls_we) begin
              mem_wstrb = st_wstrb;
              mem_wdata = st_lanes;
            end
          end
        end
      end
      ST_LS_RESP: begin
        ls_ready = 1'b1;
        ls_err   = err_q;
        ls_rdata = (we_q || err_q) ? 32'h0 : ld_value;
        if_rdata = inst_hold_q;
        state_d  = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Saturating count of cycles in which fetch was held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (if_stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

endmodule : mem_port_ctrl

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural synchronous-read memory.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ready;
  logic        ls_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] stall_cnt;

  logic [31:0] tb_mem [0:1023];
  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] W0 = 32'hA000_0001;
  localparam logic [31:0] W1 = 32'hB000_0002;
  localparam logic [31:0] W2 = 32'hC000_0003;

  mem_port_ctrl #(.AW(32), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_stall    (if_stall),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_size     (ls_size),
    .ls_unsigned (ls_unsigned),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_rdata    (ls_rdata),
    .ls_ready    (ls_ready),
    .ls_err      (ls_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory macro with byte strobes
  always @(posedge clk) begin
    mem_rdata <= tb_mem[mem_addr[11:2]];
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_wstrb[k]) tb_mem[mem_addr[11:2]][31-8*k -: 8] = mem_wdata[31-8*k -: 8];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    ls_req      = 1'b1;
    ls_we       = we;
    ls_size     = sz;
    ls_unsigned = uns;
    ls_addr     = addr;
    ls_wdata    = wd;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00;
    ls_unsigned = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0;
    step(); step();
    n_checks++; if (if_stall !== 1'b0) $display("FAIL reset_if_stall got %b want 0", if_stall); else n_pass++;
    n_checks++; if (ls_ready !== 1'b0) $display("FAIL reset_ls_ready got %b want 0", ls_ready); else n_pass++;
    n_checks++; if (ls_err !== 1'b0) $display("FAIL reset_ls_err got %b want 0", ls_err); else n_pass++;
    n_checks++; if (ls_rdata !== 32'h0) $display("FAIL reset_ls_rdata got %h want 0", ls_rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0 || mem_wstrb !== 4'b0) $display("FAIL reset_mem_we got %b/%b want 0/0000", mem_we, mem_wstrb); else n_pass++;
    n_checks++; if (stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else n_pass++;
    rst_n = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_idle_fetch();
    logic [31:0] exp_w [3];
    exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2;
    for (int n = 0; n < 3; n++) begin
      if_addr = 32'(4 * n);
      #1;
      n_checks++; if (mem_addr !== 32'(4 * n)) $display("FAIL fetch_mem_addr%0d got %h want %h", n, mem_addr, 32'(4 * n)); else n_pass++;
      step();
      n_checks++; if (if_rdata !== exp_w[n]) $display("FAIL fetch_rdata%0d got %h want %h", n, if_rdata, exp_w[n]); else n_pass++;
      n_checks++; if (if_stall !== 1'b0) $display("FAIL fetch_stall%0d got %b want 0", n, if_stall); else n_pass++;
      $display("fetch: addr=%h if_rdata=%h", if_addr, if_rdata);
    end
    n_checks++; if (stall_cnt !== 32'h0) $display("FAIL fetch_stall_cnt got %0d want 0", stall_cnt); else n_pass++;
  endtask

  task automatic test_word_load();
    logic [31:0] hold_exp;
    tb_mem[32'h100 >> 2] = 32'h1122_3344;
    hold_exp = mem_rdata;   // bench memory output, i.e. W2 from the last fetch
    drive_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    n_checks++; if (mem_addr !== 32'h100) $display("FAIL wload_mem_addr got %h want 00000100", mem_addr); else n_pass++;
    n_checks++; if (if_stall !== 1'b1) $display("FAIL wload_if_stall got %b want 1", if_stall); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL wload_mem_we got %b want 0", mem_we); else n_pass++;
    step();
    n_checks++; if (ls_ready !== 1'b1) $display("FAIL wload_ready got %b want 1", ls_ready); else n_pass++;
    n_checks++; if (ls_rdata !== 32'h4433_2211) $display("FAIL wload_rdata got %h want 44332211", ls_rdata); else n_pass++;
    n_checks++; if (if_rdata !== hold_exp) $display("FAIL wload_inst_hold got %h want %h", if_rdata, hold_exp); else n_pass++;
    n_checks++; if (stall_cnt !== 32'd1) $display("FAIL wload_stall_cnt got %0d want 1", stall_cnt); else n_pass++;
    n_checks++; if (if_stall !== 1'b0) $display("FAIL wload_resp_stall got %b want 0", if_stall); else n_pass++;
    $display("word load: addr=100 ls_rdata=%h", ls_rdata);
    ls_req = 1'b0;
    step();
    n_checks++; if (ls_ready !== 1'b0) $display("FAIL wload_ready_pulse got %b want 0", ls_ready); else n_pass++;
  endtask

  task automatic test_byte_load();
    tb_mem[32'h100 >> 2] = 32'h0000_00F0;
    drive_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    step();
    n_checks++; if (ls_rdata !== 32'hFFFF_FFF0) $display("FAIL bload_signed got %h want fffffff0", ls_rdata); else n_pass++;
    $display("byte load signed: addr=103 ls_rdata=%h", ls_rdata);
    ls_req = 1'b0;
    step();
    drive_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    step();
    n_checks++; if (ls_rdata !== 32'h0000_00F0) $display("FAIL bload_unsigned got %h want 000000f0", ls_rdata); else n_pass++;
    $display("byte load unsigned: addr=103 ls_rdata=%h", ls_rdata);
    ls_req = 1'b0;
    step();
    n_checks++; if (stall_cnt !== 32'd3) $display("FAIL bload_stall_cnt got %0d want 3", stall_cnt); else n_pass++;
  endtask

  task automatic test_half_store();
    tb_mem[32'h200 >> 2] = 32'h1234_5678;
    drive_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_BEEF);
    n_checks++; if (mem_we !== 1'b1) $display("FAIL hstore_we got %b want 1", mem_we); else n_pass++;
    n_checks++; if (mem_wstrb !== 4'b1100) $display("FAIL hstore_wstrb got %b want 1100", mem_wstrb); else n_pass++;
    n_checks++; if (mem_wdata[15:0] !== 16'hEFBE) $display("FAIL hstore_lanes got %h want EFBE", mem_wdata[15:0]); else n_pass++;
    n_checks++; if (mem_addr !== 32'h200) $display("FAIL hstore_addr got %h want 00000200", mem_addr); else n_pass++;
    step();
    n_checks++; if (mem_we !== 1'b0) $display("FAIL hstore_we_once got %b want 0", mem_we); else n_pass++;
    n_checks++; if (ls_ready !== 1'b1 || ls_rdata !== 32'h0) $display("FAIL hstore_resp got %b/%h want 1/00000000", ls_ready, ls_rdata); else n_pass++;
    ls_req = 1'b0;
    step();
    n_checks++; if (tb_mem[32'h200 >> 2] !== 32'h1234_EFBE) $display("FAIL hstore_mem got %h want 1234efbe", tb_mem[32'h200 >> 2]); else n_pass++;
    $display("half store: addr=202 mem=%h", tb_mem[32'h200 >> 2]);
  endtask

  task automatic test_misaligned();
    if_addr = 32'h8;
    drive_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
    n_checks++; if (mem_we !== 1'b0) $display("FAIL mis_we got %b want 0", mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h8) $display("FAIL mis_mem_addr got %h want 00000008", mem_addr); else n_pass++;
    n_checks++; if (if_stall !== 1'b1) $display("FAIL mis_stall got %b want 1", if_stall); else n_pass++;
    step();
    n_checks++; if (ls_ready !== 1'b1) $display("FAIL mis_ready got %b want 1", ls_ready); else n_pass++;
    n_checks++; if (ls_err !== 1'b1) $display("FAIL mis_err got %b want 1", ls_err); else n_pass++;
    n_checks++; if (ls_rdata !== 32'h0) $display("FAIL mis_rdata got %h want 0", ls_rdata); else n_pass++;
    $display("misaligned word load: addr=101 err=%b", ls_err);
    ls_req = 1'b0;
    step();
  endtask

  task automatic test_redirect();
    drive_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    step();
    if_addr = 32'h40;
    #1;
    n_checks++; if (mem_addr !== 32'h40) $display("FAIL redirect_addr got %h want 00000040", mem_addr); else n_pass++;
    n_checks++; if (ls_ready !== 1'b1) $display("FAIL redirect_ready got %b want 1", ls_ready); else n_pass++;
    $display("redirect: mem_addr=%h in response cycle", mem_addr);
    ls_req = 1'b0;
    if_addr = 32'h8;
    step();
  endtask

  task automatic test_back_to_back();
    drive_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    n_checks++; if (if_stall !== 1'b1) $display("FAIL b2b_stall1 got %b want 1", if_stall); else n_pass++;
    step();
    n_checks++; if (ls_ready !== 1'b1 || if_stall !== 1'b0) $display("FAIL b2b_resp1 got %b/%b want 1/0", ls_ready, if_stall); else n_pass++;
    step();
    n_checks++; if (ls_ready !== 1'b0 || if_stall !== 1'b1) $display("FAIL b2b_grant2 got %b/%b want 0/1", ls_ready, if_stall); else n_pass++;
    step();
    n_checks++; if (ls_ready !== 1'b1 || ls_rdata !== 32'hFFFF_FFF0) $display("FAIL b2b_resp2 got %b/%h want 1/fffffff0", ls_ready, ls_rdata); else n_pass++;
    $display("back to back: second ls_rdata=%h", ls_rdata);
    ls_req = 1'b0;
    step();
  endtask

  task automatic test_reset_in_resp();
    drive_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ls_ready !== 1'b0) $display("FAIL rstresp_ready got %b want 0", ls_ready); else n_pass++;
    n_checks++; if (if_stall !== 1'b0) $display("FAIL rstresp_stall got %b want 0", if_stall); else n_pass++;
    n_checks++; if (ls_err !== 1'b0 || ls_rdata !== 32'h0) $display("FAIL rstresp_ls got %b/%h want 0/0", ls_err, ls_rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0 || mem_wstrb !== 4'b0) $display("FAIL rstresp_mem got %b/%b want 0/0000", mem_we, mem_wstrb); else n_pass++;
    n_checks++; if (stall_cnt !== 32'h0) $display("FAIL rstresp_cnt got %0d want 0", stall_cnt); else n_pass++;
    ls_req = 1'b0;
    step();
    n_checks++; if (ls_ready !== 1'b0) $display("FAIL rstresp_no_pulse got %b want 0", ls_ready); else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++; if (ls_ready !== 1'b0 || if_stall !== 1'b0) $display("FAIL rstresp_after got %b/%b want 0/0", ls_ready, if_stall); else n_pass++;
    $display("reset in response: aborted, ls_ready=%b", ls_ready);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
    tb_mem[0] = W0;
    tb_mem[1] = W1;
    tb_mem[2] = W2;
    test_reset();
    test_idle_fetch();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_redirect();
    test_back_to_back();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_port_ctrl
